// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
//   Shared types and helpers for the priority_encoder_scan block.
//
//   Contents:
//     state_t     - scan controller states (IDLE, SCAN)
//     MAX_W       - widest request vector the helper functions handle
//     vec_t       - MAX_W-bit vector type used by the helpers
//     idx_t       - index type wide enough for any bit of vec_t
//     onehot_clr  - returns a vector with one indexed bit cleared
//     popcnt_le1  - true when a vector has at most one bit set
//
//   Callers narrower than MAX_W zero-extend into vec_t and truncate results
//   back to their own width; the upper bits never carry information.
// -----------------------------------------------------------------------------
package prio_enc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int MAX_W     = 64;
   localparam int MAX_IDX_W = $clog2(MAX_W);

   typedef logic [MAX_W-1:0]     vec_t;
   typedef logic [MAX_IDX_W-1:0] idx_t;

   // Clear bit 'idx' of 'vec'; all other bits pass through unchanged.
   function automatic vec_t onehot_clr(vec_t vec, idx_t idx);
      vec_t mask;
      mask = vec_t'(1) << idx;
      return vec & ~mask;
   endfunction

   // At most one bit set: removing the lowest set bit leaves nothing.
   // An all-zero vector also qualifies, which makes the zero beat a last beat.
   function automatic logic popcnt_le1(vec_t vec);
      return (vec & (vec - vec_t'(1))) == '0;
   endfunction

endpackage

// File: rtl/priority_encoder_scan_if.sv
// -----------------------------------------------------------------------------
// priority_encoder_scan_if
//   Input (request vector) and output (index stream) handshakes of the
//   priority_encoder_scan block, bundled as one interface.
//
//   Parameter:
//     WIDTH     - request vector width (>= 2); IDX_W is derived from it
//
//   Signals:
//     in_valid  - request vector valid
//     in_ready  - block can accept a vector
//     in_data   - request vector (WIDTH bits)
//     out_valid - out_idx valid
//     out_ready - downstream accepts the current index
//     out_idx   - index of the current highest-priority pending bit
//     out_last  - current beat is the last for this vector
//     out_zero  - accepted vector was all-zero (qualified by out_valid)
//
//   Modports:
//     master - the side that supplies vectors and consumes indices
//     slave  - the encoder itself
// -----------------------------------------------------------------------------
interface priority_encoder_scan_if #(
   parameter int WIDTH = 8
);

   localparam int IDX_W = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_zero;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_idx,
      input  out_last,
      input  out_zero
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_idx,
      output out_last,
      output out_zero
   );

endinterface

// File: rtl/prio_enc_comb.sv
// -----------------------------------------------------------------------------
// prio_enc_comb
//   Generic combinational priority encoder.
//
//   Parameters:
//     WIDTH     - input vector width (>= 2)
//     MSB_FIRST - 1: highest set bit wins; 0: lowest set bit wins
//
//   Ports:
//     vec - input vector
//     idx - index of the winning bit; 0 when vec is all-zero
//     any - at least one bit of vec is set
//
//   idx is only ever assigned a loop index below WIDTH, so for
//   non-power-of-2 widths it never exceeds WIDTH-1.
// -----------------------------------------------------------------------------
module prio_enc_comb #(
   parameter  int WIDTH     = 8,
   parameter  int MSB_FIRST = 1,
   localparam int IDX_W     = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // The scan direction is chosen so that the winning bit is the one
   // visited last; later assignments override earlier ones.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment, otherwise synthesis infers a latch.
      idx = '0;
      any = |vec;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
               idx = IDX_W'(i);
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
               idx = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/priority_encoder_scan.sv
// -----------------------------------------------------------------------------
// priority_encoder_scan
//   Sequential priority encoder: accepts a WIDTH-bit request vector and emits
//   the index of every set bit, one per beat, in priority order, clearing each
//   bit as it is emitted. An all-zero vector yields a single beat with
//   out_idx = 0, out_zero = 1, out_last = 1.
//
//   Parameters:
//     WIDTH     - request vector width (>= 2, <= prio_enc_pkg::MAX_W)
//     MSB_FIRST - 1: highest set bit first; 0: lowest set bit first
//     IDX_W     - derived index width, not overridable
//
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     flush - (only with PRIO_SCAN_FLUSH_EN) abandon the current vector
//     bus   - priority_encoder_scan_if.slave: in_valid/in_ready/in_data,
//             out_valid/out_ready/out_idx/out_last/out_zero
//
//   Optional feature macro: PRIO_SCAN_FLUSH_EN
//     Defined     : adds the flush input. flush clears pend and forces IDLE on
//                   the next edge, beating both a simultaneous output transfer
//                   and a simultaneous input handshake; in_ready is held low
//                   while flush is high.
//     Not defined : no flush port; a scan ends only by draining or by reset.
//
//   Timing: the first index is visible the cycle after the input handshake.
//   A new vector can be taken on the last beat of the previous one, so
//   back-to-back vectors stream with no idle cycle in between.
// -----------------------------------------------------------------------------
module priority_encoder_scan
   import prio_enc_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int MSB_FIRST = 1,
   localparam int IDX_W     = $clog2(WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef PRIO_SCAN_FLUSH_EN
   input  logic                    flush,
`endif
   priority_encoder_scan_if.slave  bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q,  pend_d;
   logic             zero_q,  zero_d;

   logic [IDX_W-1:0] enc_idx;
   logic             enc_any;
   logic             pend_le1;
   logic [WIDTH-1:0] pend_clr;
   logic             in_fire;
   logic             out_fire;
   logic             flush_req;

`ifdef PRIO_SCAN_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Priority selection on the registered pending vector
   // --------------------------------------------------------------------------
   prio_enc_comb #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_enc (
      .vec (pend_q),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign pend_le1 = popcnt_le1(vec_t'(pend_q));
   assign pend_clr = WIDTH'(onehot_clr(vec_t'(pend_q), idx_t'(enc_idx)));

   // --------------------------------------------------------------------------
   // Output decode: everything is a function of the registered state, so the
   // outputs hold still under backpressure without extra holding registers.
   // --------------------------------------------------------------------------
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_idx   = '0;
      bus.out_last  = 1'b0;
      bus.out_zero  = 1'b0;
      bus.in_ready  = 1'b1;
      if (state_q == SCAN) begin
         bus.out_valid = 1'b1;
         bus.out_idx   = enc_idx;
         bus.out_last  = pend_le1;
         bus.out_zero  = zero_q;
         // A new vector may only enter as the final index leaves.
         bus.in_ready  = bus.out_ready && pend_le1;
      end
      if (flush_req) begin
         bus.in_ready = 1'b0;
      end
   end

   assign in_fire  = bus.in_valid  && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   // --------------------------------------------------------------------------
   // Next-state logic. Later assignments take priority: an input handshake
   // overrides the drain of the last beat, and flush overrides everything.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      zero_d  = zero_q;

      if (out_fire) begin
         // The zero-vector beat has no bit to clear.
         if (enc_any) begin
            pend_d = pend_clr;
         end
         if (pend_le1) begin
            state_d = IDLE;
         end
      end

      if (in_fire) begin
         pend_d  = bus.in_data;
         zero_d  = (bus.in_data == '0);
         state_d = SCAN;
      end

      if (flush_req) begin
         pend_d  = '0;
         state_d = IDLE;
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: pend is a plain control register, not a memory array, so it is
      // reset together with the state; a discarded vector must never reappear.
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         zero_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         pend_q  <= pend_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_priority_encoder_scan.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_scan
//   Two encoder instances: u0 (WIDTH=8, MSB_FIRST=1) and u1 (WIDTH=12,
//   MSB_FIRST=0). A queue-based model expands each accepted vector into its
//   list of expected beats; one compare process checks both instances on every
//   falling edge. Directed scenarios pin the model with literal expectations,
//   then randomized traffic runs on both instances.
// -----------------------------------------------------------------------------
module tb_priority_encoder_scan;

   localparam int W0 = 8;
   localparam int W1 = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   priority_encoder_scan_if #(.WIDTH(W0)) if0 ();
   priority_encoder_scan_if #(.WIDTH(W1)) if1 ();

`ifdef PRIO_SCAN_FLUSH_EN
   logic flush0 = 1'b0;
   logic flush1 = 1'b0;
`endif

   priority_encoder_scan #(.WIDTH(W0), .MSB_FIRST(1)) u0 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef PRIO_SCAN_FLUSH_EN
      .flush (flush0),
`endif
      .bus   (if0)
   );

   priority_encoder_scan #(.WIDTH(W1), .MSB_FIRST(0)) u1 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef PRIO_SCAN_FLUSH_EN
      .flush (flush1),
`endif
      .bus   (if1)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: per instance, a queue of beats still owed. Beat = idx | last<<8 |
   // zero<<9.
   // ---------------------------------------------------------------------------
   int exp_q [2][$];

   function automatic void push_beats(int inst, logic [31:0] vec, int width, bit msb_first);
      int order[$];
      for (int b = 0; b < width; b++) begin
         if (vec[b]) begin
            if (msb_first) order.push_front(b);
            else           order.push_back(b);
         end
      end
      if (order.size() == 0) begin
         exp_q[inst].push_back(0 | 256 | 512);
      end else begin
         foreach (order[k]) begin
            exp_q[inst].push_back(order[k] | ((k == order.size() - 1) ? 256 : 0));
         end
      end
   endfunction

   logic [31:0] m_iv [2], m_din [2], m_ordy [2], m_ov [2], m_oi [2], m_ol [2], m_oz [2], m_ir [2];
   bit          m_fl [2];
   int          m_sz, m_front;
   bit          m_exp_valid, m_exp_rdy;

   always @(negedge clk) begin
      m_iv[0]   = 32'(if0.in_valid);   m_iv[1]   = 32'(if1.in_valid);
      m_din[0]  = 32'(if0.in_data);    m_din[1]  = 32'(if1.in_data);
      m_ordy[0] = 32'(if0.out_ready);  m_ordy[1] = 32'(if1.out_ready);
      m_ov[0]   = 32'(if0.out_valid);  m_ov[1]   = 32'(if1.out_valid);
      m_oi[0]   = 32'(if0.out_idx);    m_oi[1]   = 32'(if1.out_idx);
      m_ol[0]   = 32'(if0.out_last);   m_ol[1]   = 32'(if1.out_last);
      m_oz[0]   = 32'(if0.out_zero);   m_oz[1]   = 32'(if1.out_zero);
      m_ir[0]   = 32'(if0.in_ready);   m_ir[1]   = 32'(if1.in_ready);
      m_fl[0]   = 1'b0;                m_fl[1]   = 1'b0;
`ifdef PRIO_SCAN_FLUSH_EN
      m_fl[0]   = flush0;              m_fl[1]   = flush1;
`endif
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            exp_q[i].delete();
            check($sformatf("u%0d reset out_valid", i), m_ov[i], 32'd0);
            check($sformatf("u%0d reset out_idx", i),   m_oi[i], 32'd0);
            check($sformatf("u%0d reset out_last", i),  m_ol[i], 32'd0);
            check($sformatf("u%0d reset out_zero", i),  m_oz[i], 32'd0);
         end else begin
            m_sz        = exp_q[i].size();
            m_exp_valid = (m_sz > 0);
            check($sformatf("u%0d out_valid", i), m_ov[i], 32'(m_exp_valid));
            if (m_exp_valid) begin
               m_front = exp_q[i][0];
               check($sformatf("u%0d out_idx", i),  m_oi[i], 32'(m_front & 255));
               check($sformatf("u%0d out_last", i), m_ol[i], 32'((m_front >> 8) & 1));
               check($sformatf("u%0d out_zero", i), m_oz[i], 32'((m_front >> 9) & 1));
            end
            m_exp_rdy = !m_fl[i] && (m_sz == 0 || (m_sz == 1 && m_ordy[i][0]));
            check($sformatf("u%0d in_ready", i), m_ir[i], 32'(m_exp_rdy));
            if (m_fl[i]) begin
               exp_q[i].delete();
            end else begin
               if (m_exp_valid && m_ordy[i][0]) void'(exp_q[i].pop_front());
               if (m_iv[i][0] && m_exp_rdy)
                  push_beats(i, m_din[i], (i == 0) ? W0 : W1, (i == 0));
            end
         end
      end
   end

   // Inputs change 1 time unit after the rising edge; literal checks sample
   // a further unit later, well clear of either edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   int got[$];

   initial begin
      if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("reset in_ready", 32'(if0.in_ready), 32'd1);
      check("reset out_valid", 32'(if0.out_valid), 32'd0);

      // 1: 1010_0100 -> 7, 5, 2
      if0.in_valid = 1'b1; if0.in_data = 8'hA4;
      next_cycle(); if0.in_valid = 1'b0; #1;
      check("t1 b0 idx", 32'(if0.out_idx), 32'd7);
      check("t1 b0 last", 32'(if0.out_last), 32'd0);
      check("t1 b0 in_ready", 32'(if0.in_ready), 32'd0);
      next_cycle(); #1;
      check("t1 b1 idx", 32'(if0.out_idx), 32'd5);
      check("t1 b1 in_ready", 32'(if0.in_ready), 32'd0);
      next_cycle(); #1;
      check("t1 b2 idx", 32'(if0.out_idx), 32'd2);
      check("t1 b2 last", 32'(if0.out_last), 32'd1);
      next_cycle(); #1;
      check("t1 idle out_valid", 32'(if0.out_valid), 32'd0);

      // 2: zero vector
      if0.in_valid = 1'b1; if0.in_data = 8'h00;
      next_cycle(); if0.in_valid = 1'b0; #1;
      check("t2 valid", 32'(if0.out_valid), 32'd1);
      check("t2 idx", 32'(if0.out_idx), 32'd0);
      check("t2 zero", 32'(if0.out_zero), 32'd1);
      check("t2 last", 32'(if0.out_last), 32'd1);
      next_cycle(); #1;
      check("t2 idle out_valid", 32'(if0.out_valid), 32'd0);
      check("t2 idle in_ready", 32'(if0.in_ready), 32'd1);

      // 3: FF with out_ready 1,0,0,1,0,0,...
      if0.in_valid = 1'b1; if0.in_data = 8'hFF;
      next_cycle(); if0.in_valid = 1'b0;
      got.delete();
      for (int k = 0; k < 40; k++) begin
         if0.out_ready = (k % 3 == 0);
         #1;
         if (if0.out_valid && if0.out_ready) got.push_back(int'(if0.out_idx));
         next_cycle();
         if (got.size() == 8) break;
      end
      check("t3 beat count", 32'(got.size()), 32'd8);
      foreach (got[j]) check($sformatf("t3 beat %0d idx", j), 32'(got[j]), 32'(7 - j));
      if0.out_ready = 1'b1;
      #1;
      check("t3 idle out_valid", 32'(if0.out_valid), 32'd0);

      // 4: back-to-back 1000_0001 then 0001_0000 on the last beat
      if0.in_valid = 1'b1; if0.in_data = 8'h81;
      next_cycle(); if0.in_valid = 1'b0; #1;
      check("t4 b0 idx", 32'(if0.out_idx), 32'd7);
      next_cycle(); if0.in_valid = 1'b1; if0.in_data = 8'h10; #1;
      check("t4 b1 idx", 32'(if0.out_idx), 32'd0);
      check("t4 b1 last", 32'(if0.out_last), 32'd1);
      check("t4 b1 in_ready", 32'(if0.in_ready), 32'd1);
      next_cycle(); if0.in_valid = 1'b0; #1;
      check("t4 b2 valid", 32'(if0.out_valid), 32'd1);
      check("t4 b2 idx", 32'(if0.out_idx), 32'd4);
      check("t4 b2 last", 32'(if0.out_last), 32'd1);
      next_cycle(); #1;
      check("t4 idle out_valid", 32'(if0.out_valid), 32'd0);

      // 5: WIDTH=12, LSB first, 12'h804 -> 2, 11
      if1.in_valid = 1'b1; if1.in_data = 12'h804;
      next_cycle(); if1.in_valid = 1'b0; #1;
      check("t5 b0 idx", 32'(if1.out_idx), 32'd2);
      check("t5 b0 last", 32'(if1.out_last), 32'd0);
      next_cycle(); #1;
      check("t5 b1 idx", 32'(if1.out_idx), 32'd11);
      check("t5 b1 last", 32'(if1.out_last), 32'd1);
      next_cycle(); #1;
      check("t5 idle out_valid", 32'(if1.out_valid), 32'd0);

      // 6: reset during the 2nd beat of F0
      if0.in_valid = 1'b1; if0.in_data = 8'hF0;
      next_cycle(); if0.in_valid = 1'b0; #1;
      check("t6 b0 idx", 32'(if0.out_idx), 32'd7);
      next_cycle(); #1;
      check("t6 b1 idx", 32'(if0.out_idx), 32'd6);
      rst_n = 1'b0; #1;
      check("t6 async out_valid", 32'(if0.out_valid), 32'd0);
      check("t6 async out_idx", 32'(if0.out_idx), 32'd0);
      next_cycle(); next_cycle();
      rst_n = 1'b1; #1;
      check("t6 release in_ready", 32'(if0.in_ready), 32'd1);
      if0.in_valid = 1'b1; if0.in_data = 8'h01;
      next_cycle(); if0.in_valid = 1'b0; #1;
      check("t6 new idx", 32'(if0.out_idx), 32'd0);
      check("t6 new last", 32'(if0.out_last), 32'd1);
      check("t6 new zero", 32'(if0.out_zero), 32'd0);
      next_cycle();

`ifdef PRIO_SCAN_FLUSH_EN
      // 6b: flush in the same position
      if0.in_valid = 1'b1; if0.in_data = 8'hF0;
      next_cycle(); if0.in_valid = 1'b0;
      next_cycle(); flush0 = 1'b1; #1;
      check("t6f in_ready during flush", 32'(if0.in_ready), 32'd0);
      next_cycle(); flush0 = 1'b0; #1;
      check("t6f out_valid after flush", 32'(if0.out_valid), 32'd0);
      check("t6f in_ready after flush", 32'(if0.in_ready), 32'd1);
`endif

      // Randomized traffic on both instances
      for (int n = 0; n < 3000; n++) begin
         if0.in_valid  = ($urandom % 2) == 0;
         if0.out_ready = ($urandom % 4) != 0;
         case ($urandom % 8)
            0:       if0.in_data = '0;
            1:       if0.in_data = W0'(32'd1 << ($urandom % W0));
            default: if0.in_data = W0'($urandom);
         endcase
         if1.in_valid  = ($urandom % 2) == 0;
         if1.out_ready = ($urandom % 4) != 0;
         case ($urandom % 8)
            0:       if1.in_data = '0;
            1:       if1.in_data = W1'(32'd1 << ($urandom % W1));
            default: if1.in_data = W1'($urandom);
         endcase
         next_cycle();
      end

      if0.in_valid = 1'b0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.out_ready = 1'b1;
      repeat (20) next_cycle();
      check("drain u0 out_valid", 32'(if0.out_valid), 32'd0);
      check("drain u1 out_valid", 32'(if1.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
